fpu_cmd_sequencer: RTL and testbench

- Upstream command stage for the fpu block: buffers floating-point operation requests (A, B, op) arriving on a valid/ready interface.
- Issues requests one at a time to the fpu using its start/done handshake.
- Captures R and presents it on a valid/ready result port.
- Enforces a response timeout, since the fpu can take up to 2000 cycles.

---
 rtl/fpu_pkg.sv | 16 +
 rtl/fpu_cmd_fifo.sv | 51 +++++
 rtl/fpu_cmd_sequencer.sv | 157 +++++++++++++++
 tb/tb_fpu_cmd_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the fpu command sequencer: op codes, the timeout
// result value and the sequencer FSM state encoding.
package fpu_pkg;

    localparam logic [1:0]  OP_ADD = 2'b00;
    localparam logic [1:0]  OP_MUL = 2'b10;
    localparam logic [31:0] QNAN   = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StHold  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/fpu_cmd_fifo.sv
// Synchronous command FIFO; full/empty come from an extra wrap bit on each
// pointer, and the head entry is always presented on head_o.
module fpu_cmd_fifo #(
    parameter int unsigned Width = 66,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AddrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
    logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                     (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AddrW-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AddrW + 1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AddrW + 1)'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/fpu_cmd_sequencer.sv
// Buffers fpu requests, issues them one at a time with a start/done
// handshake, and holds each result (or a timeout qNaN) in a single slot.
module fpu_cmd_sequencer
    import fpu_pkg::*;
#(
    parameter int unsigned W       = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 2000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [1:0]   in_op,
    output logic [W-1:0] fpu_a,
    output logic [W-1:0] fpu_b,
    output logic [1:0]   fpu_op,
    output logic         fpu_start,
    input  logic         fpu_done,
    input  logic [W-1:0] fpu_r,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_r,
    output logic [1:0]   out_op,
    output logic         out_err
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam int unsigned EntW = 2 * W + 2;

    logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [EntW-1:0] fifo_head;
    logic [W-1:0]    head_a, head_b;
    logic [1:0]      head_op;

    seq_state_e      state_q, state_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            done_q;
    logic [W-1:0]    fpu_a_q, fpu_a_d, fpu_b_q, fpu_b_d;
    logic [1:0]      fpu_op_q, fpu_op_d;
    logic            fpu_start_q, fpu_start_d;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_r_q, out_r_d;
    logic [1:0]      out_op_q, out_op_d;
    logic            out_err_q, out_err_d;
    logic            done_edge, timed_out;

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && !fifo_full;
    assign {head_a, head_b, head_op} = fifo_head;

    fpu_cmd_fifo #(
        .Width (EntW),
        .Depth (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (fifo_push),
        .data_i  ({in_a, in_b, in_op}),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A done level carried over from the previous op must not complete this one.
    assign done_edge = fpu_done && !done_q;
    // Counter is 0 on the first WAIT cycle, so WAIT runs TIMEOUT cycles before the abort cycle.
    assign timed_out = (wait_cnt_q == CntW'(TIMEOUT));

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        fpu_a_d     = fpu_a_q;
        fpu_b_d     = fpu_b_q;
        fpu_op_d    = fpu_op_q;
        fpu_start_d = 1'b0;
        out_valid_d = out_valid_q;
        out_r_d     = out_r_q;
        out_op_d    = out_op_q;
        out_err_d   = out_err_q;
        fifo_pop    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fpu_a_d     = head_a;
                    fpu_b_d     = head_b;
                    fpu_op_d    = head_op;
                    fpu_start_d = 1'b1;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                wait_cnt_d = '0;
                state_d    = StWait;
            end
            StWait: begin
                wait_cnt_d = wait_cnt_q + CntW'(1);
                if (done_edge || timed_out) begin
                    out_r_d     = done_edge ? fpu_r : W'(QNAN);
                    out_err_d   = !done_edge;
                    out_op_d    = fpu_op_q;
                    out_valid_d = 1'b1;
                    fifo_pop    = 1'b1;
                    state_d     = StHold;
                end
            end
            StHold: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            wait_cnt_q  <= '0;
            done_q      <= 1'b0;
            fpu_a_q     <= '0;
            fpu_b_q     <= '0;
            fpu_op_q    <= '0;
            fpu_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            out_op_q    <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            done_q      <= fpu_done;
            fpu_a_q     <= fpu_a_d;
            fpu_b_q     <= fpu_b_d;
            fpu_op_q    <= fpu_op_d;
            fpu_start_q <= fpu_start_d;
            out_valid_q <= out_valid_d;
            out_r_q     <= out_r_d;
            out_op_q    <= out_op_d;
            out_err_q   <= out_err_d;
        end
    end

    assign fpu_a     = fpu_a_q;
    assign fpu_b     = fpu_b_q;
    assign fpu_op    = fpu_op_q;
    assign fpu_start = fpu_start_q;
    assign out_valid = out_valid_q;
    assign out_r     = out_r_q;
    assign out_op    = out_op_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
// Scoreboard bench: commands queue expected results in order, an fpu model
// answers start pulses, and a monitor checks each result as it appears.
module tb_fpu_cmd_sequencer;
    import fpu_pkg::*;

    localparam int unsigned W       = 32;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 2000;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready;
    logic [W-1:0] in_a, in_b;
    logic [1:0]   in_op;
    logic [W-1:0] fpu_a, fpu_b;
    logic [1:0]   fpu_op;
    logic         fpu_start;
    logic         fpu_done;
    logic [W-1:0] fpu_r;
    logic         out_valid, out_ready;
    logic [W-1:0] out_r;
    logic [1:0]   out_op;
    logic         out_err;

    fpu_cmd_sequencer #(
        .W       (W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .fpu_a     (fpu_a),
        .fpu_b     (fpu_b),
        .fpu_op    (fpu_op),
        .fpu_start (fpu_start),
        .fpu_done  (fpu_done),
        .fpu_r     (fpu_r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_op    (out_op),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        int          lat;        // -1: the fpu never answers
        bit          stale;      // keep the previous done high into this op
        int          exp_start;  // -1: start cycle not checked
    } cmd_t;

    typedef struct {
        logic [31:0] r;
        logic [1:0]  op;
        logic        err;
    } res_t;

    cmd_t issue_q[$];
    res_t exp_q[$];
    int   rise_q[$];

    int vectors = 0;
    int miscompares = 0;
    int n_accepted = 0;
    int n_starts = 0;
    bit rnd_ready = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Stand-in fpu: exact for the directed operands, a cheap mixing function otherwise.
    function automatic logic [31:0] fpu_func(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] op);
        if (op == OP_ADD && a == 32'h3FA0_0000 && b == 32'h3FC0_0000) return 32'h4030_0000;
        if (op == OP_MUL && a == 32'h4020_0000 && b == 32'h4098_0000) return 32'h413E_0000;
        return (a + b) ^ {op, 30'h0};
    endfunction

    initial begin : fpu_model
        cmd_t cur;
        bit   busy;
        bit   prev_start;
        int   due;
        int   drop_at;
        busy = 0; prev_start = 0; due = 0; drop_at = -1;
        fpu_done = 1'b0;
        fpu_r = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                busy = 0; prev_start = 0; drop_at = -1;
                fpu_done = 1'b0;
                continue;
            end
            if (fpu_start) begin
                check("start_single_cycle", 64'(prev_start), 64'(0));
                check("start_while_busy", 64'(busy), 64'(0));
                n_starts++;
                if (issue_q.size() == 0) begin
                    flag("unexpected_start");
                end else begin
                    cur = issue_q.pop_front();
                    check("fpu_a", 64'(fpu_a), 64'(cur.a));
                    check("fpu_b", 64'(fpu_b), 64'(cur.b));
                    check("fpu_op", 64'(fpu_op), 64'(cur.op));
                    if (cur.exp_start >= 0) check("start_cycle", 64'(cyc), 64'(cur.exp_start));
                    if (cur.lat < 0) begin
                        fpu_done = 1'b0;
                        rise_q.push_back(cyc + TIMEOUT + 2);
                    end else begin
                        busy = 1;
                        due = cyc + cur.lat;
                        if (cur.stale) begin
                            drop_at = cyc + 2;
                        end else begin
                            fpu_done = 1'b0;
                            drop_at = -1;
                        end
                    end
                end
            end else begin
                if (drop_at == cyc) fpu_done = 1'b0;
                if (busy && cyc == due) begin
                    fpu_done = 1'b1;
                    fpu_r = fpu_func(cur.a, cur.b, cur.op);
                    rise_q.push_back(cyc + 1);
                    busy = 0;
                end
            end
            prev_start = fpu_start;
        end
    end

    initial begin : monitor
        bit   prev_valid;
        bit   prev_ready;
        res_t held;
        int   exp_rise;
        prev_valid = 0; prev_ready = 0;
        held = '{r: '0, op: '0, err: 1'b0};
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_valid = 0; prev_ready = 0;
                continue;
            end
            if (prev_valid && prev_ready) begin
                check("valid_drops_after_accept", 64'(out_valid), 64'(0));
            end else if (out_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    flag("unexpected_result");
                end else begin
                    held = exp_q.pop_front();
                    check("out_r", 64'(out_r), 64'(held.r));
                    check("out_op", 64'(out_op), 64'(held.op));
                    check("out_err", 64'(out_err), 64'(held.err));
                    if (rise_q.size() == 0) begin
                        flag("result_before_fpu_done");
                    end else begin
                        exp_rise = rise_q.pop_front();
                        check("result_cycle", 64'(cyc), 64'(exp_rise));
                    end
                end
            end else if (out_valid && prev_valid) begin
                check("hold_stable", {29'b0, out_err, out_op, out_r},
                      {29'b0, held.err, held.op, held.r});
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
        end
    end

    initial begin : ready_drv
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic push_cmd(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                            input int lat, input bit stale, input bit timed);
        cmd_t c;
        res_t e;
        int   waited;
        waited = 0;
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        while (!in_ready) begin
            @(posedge clk);
            #1;
            waited++;
            if (waited > 3 * TIMEOUT) begin
                flag("push_never_accepted");
                in_valid = 1'b0;
                return;
            end
        end
        c = '{a: a, b: b, op: op, lat: lat, stale: stale, exp_start: timed ? cyc + 2 : -1};
        e.r   = (lat < 0) ? QNAN : fpu_func(a, b, op);
        e.op  = op;
        e.err = (lat < 0);
        issue_q.push_back(c);
        exp_q.push_back(e);
        n_accepted++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || issue_q.size() != 0 || out_valid) && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= bound) flag("drain_timeout");
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int starts0;
        int lat;
        int n_to;
        reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_fpu_start", 64'(fpu_start), 64'(0));
        check("rst_outputs", {29'b0, out_err, out_op, out_r}, 64'(0));
        check("rst_fpu_ops", {fpu_a, fpu_b} ^ 64'(fpu_op), 64'(0));
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single add and single mul with fixed latencies.
        out_ready = 1'b1;
        push_cmd(32'h3FA0_0000, 32'h3FC0_0000, OP_ADD, 5, 0, 1);
        drain(500);
        push_cmd(32'h4020_0000, 32'h4098_0000, OP_MUL, 40, 0, 1);
        drain(500);

        // Burst of five with the result port blocked.
        out_ready = 1'b0;
        starts0 = n_starts;
        for (int i = 0; i < 4; i++) push_cmd($urandom, $urandom, OP_MUL, 30, 0, i == 0);
        check("burst_in_ready_full", 64'(in_ready), 64'(0));
        push_cmd($urandom, $urandom, OP_ADD, 30, 0, 0);
        repeat (20) @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain(2000);
        check("burst_start_count", 64'(n_starts - starts0), 64'(5));

        // Timeout followed by a normal op.
        push_cmd(32'h1111_1111, 32'h2222_2222, OP_ADD, -1, 0, 1);
        push_cmd(32'h3333_3333, 32'h4444_4444, OP_MUL, 10, 0, 0);
        drain(3 * TIMEOUT);

        // Done left high from the previous op across the next start.
        push_cmd(32'h5555_5555, 32'h6666_6666, OP_ADD, 8, 0, 1);
        push_cmd(32'h7777_7777, 32'h8888_8888, OP_MUL, 12, 1, 0);
        drain(500);

        // Reset during WAIT with three queued commands.
        for (int i = 0; i < 3; i++) push_cmd($urandom, $urandom, OP_ADD, 100, 0, i == 0);
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_fpu_start", 64'(fpu_start), 64'(0));
        issue_q.delete();
        exp_q.delete();
        rise_q.delete();
        n_accepted = 0;
        n_starts = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        check("postrst_no_start", 64'(n_starts), 64'(0));
        check("postrst_out_valid", 64'(out_valid), 64'(0));

        // Random commands, latencies, stale dones and back-pressure.
        n_to = 0;
        rnd_ready = 1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            if ($urandom_range(0, 19) == 0 && n_to < 2) begin
                lat = -1;
                n_to++;
            end else begin
                lat = $urandom_range(1, 60);
            end
            push_cmd($urandom, $urandom, 2'($urandom_range(0, 3)), lat,
                     (lat >= 4) && ($urandom_range(0, 3) == 0), 0);
        end
        rnd_ready = 0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain(4 * TIMEOUT + 4000);
        check("start_count", 64'(n_starts), 64'(n_accepted));
        check("results_left", 64'(exp_q.size()), 64'(0));
        check("final_in_ready", 64'(in_ready), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
